// File: rtl/gbuff_arbiter.sv
`timescale 1ns/1ps
// gbuff_arbiter: round-robin burst arbiter/sequencer in front of a single-port
// global buffer shared by a host load path (port 0) and a TPU compute path
// (port 1). The winner owns the buffer for the whole burst; addresses are
// generated sequentially and wrap modulo the buffer depth.
module gbuff_arbiter #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int LEN_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  // port 0
  input  logic                 p0_cmd_valid,
  output logic                 p0_cmd_ready,
  input  logic                 p0_cmd_we,
  input  logic [ADDR_BITS-1:0] p0_cmd_addr,
  input  logic [LEN_BITS-1:0]  p0_cmd_len,
  input  logic                 p0_wd_valid,
  output logic                 p0_wd_ready,
  input  logic [DATA_BITS-1:0] p0_wd_data,
  output logic                 p0_rd_valid,
  output logic [DATA_BITS-1:0] p0_rd_data,
  output logic                 p0_done,
  // port 1
  input  logic                 p1_cmd_valid,
  output logic                 p1_cmd_ready,
  input  logic                 p1_cmd_we,
  input  logic [ADDR_BITS-1:0] p1_cmd_addr,
  input  logic [LEN_BITS-1:0]  p1_cmd_len,
  input  logic                 p1_wd_valid,
  output logic                 p1_wd_ready,
  input  logic [DATA_BITS-1:0] p1_wd_data,
  output logic                 p1_rd_valid,
  output logic [DATA_BITS-1:0] p1_rd_data,
  output logic                 p1_done,
  // global buffer
  output logic                 gb_wr_en,
  output logic [ADDR_BITS-1:0] gb_index,
  output logic [DATA_BITS-1:0] gb_data_in,
  input  logic [DATA_BITS-1:0] gb_data_out
);

  localparam int NP = 2;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d, idx_q;
  logic [LEN_BITS-1:0]  rem_q, rem_d;
  logic [DATA_BITS-1:0] din_q;
  logic   rd_iss_q, rd_iss_d;
  logic   rd_tag_q, rd_tag_d;
  logic   rd_last_q, rd_last_d;

  // per-port views of the requester interfaces
  logic [NP-1:0]                cmd_valid, cmd_we, wd_valid;
  logic [NP-1:0][ADDR_BITS-1:0] cmd_addr;
  logic [NP-1:0][LEN_BITS-1:0]  cmd_len;
  logic [NP-1:0][DATA_BITS-1:0] wd_data;
  logic [NP-1:0]                cmd_ready, wd_ready, rd_valid, done;
  logic [NP-1:0][DATA_BITS-1:0] rd_data;

  logic [NP-1:0] grant;
  logic          sel;
  logic          beat_wr, beat_rd, wr_done;

  assign cmd_valid = {p1_cmd_valid, p0_cmd_valid};
  assign cmd_we    = {p1_cmd_we,    p0_cmd_we};
  assign cmd_addr  = {p1_cmd_addr,  p0_cmd_addr};
  assign cmd_len   = {p1_cmd_len,   p0_cmd_len};
  assign wd_valid  = {p1_wd_valid,  p0_wd_valid};
  assign wd_data   = {p1_wd_data,   p0_wd_data};

  // arbitration, burst sequencing and next-state logic
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    grant     = '0;
    sel       = 1'b0;
    beat_wr   = 1'b0;
    beat_rd   = 1'b0;
    wr_done   = 1'b0;
    rd_iss_d  = 1'b0;
    rd_tag_d  = rd_tag_q;
    rd_last_d = 1'b0;
    case (state_q)
      IDLE: begin
        // no acceptance while reset is held, so cmd_ready stays low then
        if (!rst && (|cmd_valid)) begin
          // a tie goes to the port that did not win last time
          sel        = (&cmd_valid) ? ~last_q : cmd_valid[1];
          grant[sel] = 1'b1;
          owner_d    = sel;
          last_d     = sel;
          addr_d     = cmd_addr[sel];
          rem_d      = cmd_len[sel];
          state_d    = cmd_we[sel] ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wd_valid[owner_q]) begin
          beat_wr = 1'b1;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == '0) begin
            wr_done = 1'b1;
            state_d = IDLE;
          end
        end
      end
      READ: begin
        // reads never stall: one issue per cycle
        beat_rd   = 1'b1;
        addr_d    = addr_q + 1'b1;
        rem_d     = rem_q - 1'b1;
        rd_iss_d  = 1'b1;
        rd_tag_d  = owner_q;
        rd_last_d = (rem_q == '0);
        if (rem_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // buffer side: index/data are live only on an issue and otherwise hold
  assign gb_wr_en   = beat_wr;
  assign gb_index   = (beat_wr || beat_rd) ? addr_q : idx_q;
  assign gb_data_in = beat_wr ? wd_data[owner_q] : din_q;

  // per-port response routing
  for (genvar g = 0; g < NP; g++) begin : g_port
    assign cmd_ready[g] = grant[g];
    assign wd_ready[g]  = (state_q == WRITE) && (owner_q == 1'(g));
    assign rd_valid[g]  = rd_iss_q && (rd_tag_q == 1'(g));
    assign rd_data[g]   = rd_valid[g] ? gb_data_out : '0;
    assign done[g]      = (wr_done && (owner_q == 1'(g))) ||
                          (rd_valid[g] && rd_last_q);
  end

  assign p0_cmd_ready = cmd_ready[0];
  assign p1_cmd_ready = cmd_ready[1];
  assign p0_wd_ready  = wd_ready[0];
  assign p1_wd_ready  = wd_ready[1];
  assign p0_rd_valid  = rd_valid[0];
  assign p1_rd_valid  = rd_valid[1];
  assign p0_rd_data   = rd_data[0];
  assign p1_rd_data   = rd_data[1];
  assign p0_done      = done[0];
  assign p1_done      = done[1];

  // state registers; reset abandons any burst and drops pending read returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      din_q     <= '0;
      rd_iss_q  <= 1'b0;
      rd_tag_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      idx_q     <= gb_index;
      din_q     <= gb_data_in;
      rd_iss_q  <= rd_iss_d;
      rd_tag_q  <= rd_tag_d;
      rd_last_q <= rd_last_d;
    end
  end

endmodule

// File: tb/tb_gbuff_arbiter.sv
`timescale 1ns/1ps
// Bench for gbuff_arbiter: table of bursts plus hand sequences for ties,
// isolation and reset; read returns are checked against a queue of expected
// beats filled when each read is issued.
module tb_gbuff_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      cmd_valid, cmd_we, wd_valid;
  logic [1:0][7:0] cmd_addr, cmd_len, wd_data;

  logic p0_cmd_ready, p1_cmd_ready, p0_wd_ready, p1_wd_ready;
  logic p0_rd_valid, p1_rd_valid, p0_done, p1_done;
  logic [7:0] p0_rd_data, p1_rd_data;
  logic gb_wr_en;
  logic [7:0] gb_index, gb_data_in, gb_data_out;

  logic [1:0] cmd_ready, wd_ready, rd_valid, done;
  logic [1:0][7:0] rd_data;
  assign cmd_ready = {p1_cmd_ready, p0_cmd_ready};
  assign wd_ready  = {p1_wd_ready, p0_wd_ready};
  assign rd_valid  = {p1_rd_valid, p0_rd_valid};
  assign done      = {p1_done, p0_done};
  assign rd_data   = {p1_rd_data, p0_rd_data};

  gbuff_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .LEN_BITS(8)) dut (
    .clk(clk), .rst(rst),
    .p0_cmd_valid(cmd_valid[0]), .p0_cmd_ready(p0_cmd_ready), .p0_cmd_we(cmd_we[0]),
    .p0_cmd_addr(cmd_addr[0]), .p0_cmd_len(cmd_len[0]),
    .p0_wd_valid(wd_valid[0]), .p0_wd_ready(p0_wd_ready), .p0_wd_data(wd_data[0]),
    .p0_rd_valid(p0_rd_valid), .p0_rd_data(p0_rd_data), .p0_done(p0_done),
    .p1_cmd_valid(cmd_valid[1]), .p1_cmd_ready(p1_cmd_ready), .p1_cmd_we(cmd_we[1]),
    .p1_cmd_addr(cmd_addr[1]), .p1_cmd_len(cmd_len[1]),
    .p1_wd_valid(wd_valid[1]), .p1_wd_ready(p1_wd_ready), .p1_wd_data(wd_data[1]),
    .p1_rd_valid(p1_rd_valid), .p1_rd_data(p1_rd_data), .p1_done(p1_done),
    .gb_wr_en(gb_wr_en), .gb_index(gb_index), .gb_data_in(gb_data_in),
    .gb_data_out(gb_data_out)
  );

  // single-port buffer, one-cycle read latency
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (gb_wr_en) mem[gb_index] <= gb_data_in;
    else          gb_data_out <= mem[gb_index];
  end

  logic [7:0] exp_mem [256];
  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [7:0] d; logic last; } ret_t;
  ret_t q0[$];
  ret_t q1[$];

  typedef struct {
    bit         p;
    bit         we;
    logic [7:0] addr;
    logic [7:0] len;
    logic [7:0] dbase;
    bit         stall;
    logic [7:0] last_idx;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ret(input bit p, input logic [7:0] d, input logic last);
    ret_t e;
    e.d = d;
    e.last = last;
    if (p) q1.push_back(e);
    else    q0.push_back(e);
  endtask

  task automatic check_ret(input bit p);
    ret_t e;
    if ((!p && q0.size() == 0) || (p && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL rd_unexpected p%0d: got rd_valid 1 expected 0", p);
    end else begin
      e = p ? q1.pop_front() : q0.pop_front();
      chk($sformatf("rd_data p%0d", p), 32'(rd_data[p]), 32'(e.d));
      chk($sformatf("rd_done p%0d", p), 32'(done[p]), 32'(e.last));
    end
  endtask

  // read-return monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid[0]) check_ret(1'b0);
      if (rd_valid[1]) check_ret(1'b1);
    end
  end

  task automatic check_all_zero(input string nm);
    chk({nm, " cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({nm, " wd_ready"}, 32'(wd_ready), 32'd0);
    chk({nm, " rd_valid"}, 32'(rd_valid), 32'd0);
    chk({nm, " done"}, 32'(done), 32'd0);
    chk({nm, " rd_data"}, 32'(rd_data), 32'd0);
    chk({nm, " gb_wr_en"}, 32'(gb_wr_en), 32'd0);
    chk({nm, " gb_index"}, 32'(gb_index), 32'd0);
    chk({nm, " gb_data_in"}, 32'(gb_data_in), 32'd0);
  endtask

  // one burst from an idle arbiter with a single requester
  task automatic run_burst(input vec_t v);
    logic [1:0] pm;
    logic [7:0] ia;
    pm = v.p ? 2'b10 : 2'b01;
    cmd_valid[v.p] = 1'b1;
    cmd_we[v.p]    = v.we;
    cmd_addr[v.p]  = v.addr;
    cmd_len[v.p]   = v.len;
    @(negedge clk);
    chk("cmd_ready grant", 32'(cmd_ready), 32'(pm));
    step();
    cmd_valid[v.p] = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      ia = v.addr + 8'(i);
      if (v.we) begin
        if (v.stall && i > 0) begin
          wd_valid[v.p] = 1'b0;
          @(negedge clk);
          chk("stall gb_wr_en", 32'(gb_wr_en), 32'd0);
          chk("stall gb_index hold", 32'(gb_index), 32'(ia - 8'd1));
          chk("stall done", 32'(done), 32'd0);
          step();
        end
        wd_valid[v.p] = 1'b1;
        wd_data[v.p]  = v.dbase + 8'(i);
        @(negedge clk);
        chk("wr gb_wr_en", 32'(gb_wr_en), 32'd1);
        chk("wr gb_index", 32'(gb_index), 32'(ia));
        chk("wr gb_data_in", 32'(gb_data_in), 32'(v.dbase + 8'(i)));
        chk("wr wd_ready", 32'(wd_ready), 32'(pm));
        chk("wr done", 32'(done), (i == int'(v.len)) ? 32'(pm) : 32'd0);
        if (i == int'(v.len)) chk("wr last index", 32'(gb_index), 32'(v.last_idx));
        exp_mem[ia] = v.dbase + 8'(i);
        step();
      end else begin
        @(negedge clk);
        chk("rd gb_wr_en", 32'(gb_wr_en), 32'd0);
        chk("rd gb_index", 32'(gb_index), 32'(ia));
        chk("rd busy cmd_ready", 32'(cmd_ready), 32'd0);
        if (i == int'(v.len)) chk("rd last index", 32'(gb_index), 32'(v.last_idx));
        push_ret(v.p, exp_mem[ia], i == int'(v.len));
        step();
      end
    end
    wd_valid[v.p] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    cmd_valid = '0; cmd_we = '0; wd_valid = '0;
    cmd_addr = '0; cmd_len = '0; wd_data = '0;

    //            p     we    addr   len    dbase  stall last_idx
    tbl[0] = '{1'b0, 1'b1, 8'h10, 8'd3, 8'hA0, 1'b0, 8'h13};
    tbl[1] = '{1'b0, 1'b0, 8'h10, 8'd3, 8'h00, 1'b0, 8'h13};
    tbl[2] = '{1'b1, 1'b1, 8'h40, 8'd2, 8'h50, 1'b1, 8'h42};
    tbl[3] = '{1'b1, 1'b0, 8'h40, 8'd2, 8'h00, 1'b0, 8'h42};
    tbl[4] = '{1'b0, 1'b1, 8'hFE, 8'd3, 8'hC0, 1'b0, 8'h01};
    tbl[5] = '{1'b1, 1'b0, 8'hFE, 8'd3, 8'h00, 1'b0, 8'h01};
    tbl[6] = '{1'b0, 1'b0, 8'h11, 8'd0, 8'h00, 1'b0, 8'h11};

    // reset state
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // table-driven bursts, back to back (reads overlap the next accept)
    for (int k = 0; k < 7; k++) run_burst(tbl[k]);
    step(); step();

    // ties after reset alternate 0,1,0,1
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    cmd_valid = 2'b11; cmd_we = 2'b00;
    cmd_addr[0] = 8'h10; cmd_addr[1] = 8'h11; cmd_len = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("tie grant %0d", k), 32'(cmd_ready), (k % 2 == 1) ? 32'd2 : 32'd1);
      step();
      @(negedge clk);
      chk("tie busy cmd_ready", 32'(cmd_ready), 32'd0);
      chk("tie gb_index", 32'(gb_index), (k % 2 == 1) ? 32'h11 : 32'h10);
      push_ret(k % 2 == 1, (k % 2 == 1) ? exp_mem[8'h11] : exp_mem[8'h10], 1'b1);
      step();
    end
    cmd_valid = 2'b00;
    step(); step();

    // non-owner isolation during a p1 read
    cmd_valid[1] = 1'b1; cmd_we[1] = 1'b0; cmd_addr[1] = 8'h40; cmd_len[1] = 8'd2;
    @(negedge clk);
    chk("iso p1 grant", 32'(cmd_ready), 32'd2);
    step();
    cmd_valid[1] = 1'b0;
    cmd_valid[0] = 1'b1; cmd_we[0] = 1'b1; cmd_addr[0] = 8'h80; cmd_len[0] = 8'd0;
    wd_valid[0] = 1'b1; wd_data[0] = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("iso p0 cmd_ready", 32'(cmd_ready[0]), 32'd0);
      chk("iso p0 wd_ready", 32'(wd_ready[0]), 32'd0);
      chk("iso p0 rd_valid", 32'(rd_valid[0]), 32'd0);
      chk("iso gb_wr_en", 32'(gb_wr_en), 32'd0);
      chk("iso gb_index", 32'(gb_index), 32'(8'h40 + 8'(i)));
      push_ret(1'b1, exp_mem[8'h40 + 8'(i)], i == 2);
      step();
    end
    @(negedge clk);
    chk("iso p0 accepted", 32'(cmd_ready), 32'd1);
    step();
    @(negedge clk);
    chk("iso p0 wr_en", 32'(gb_wr_en), 32'd1);
    chk("iso p0 index", 32'(gb_index), 32'h80);
    chk("iso p0 data", 32'(gb_data_in), 32'h77);
    chk("iso p0 done", 32'(done), 32'd1);
    exp_mem[8'h80] = 8'h77;
    step();
    cmd_valid[0] = 1'b0; wd_valid[0] = 1'b0;
    step();

    // reset during the 3rd beat of a len=7 read
    cmd_valid[0] = 1'b1; cmd_we[0] = 1'b0; cmd_addr[0] = 8'h10; cmd_len[0] = 8'd7;
    @(negedge clk);
    chk("mid grant", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid gb_index", 32'(gb_index), 32'(8'h10 + 8'(i)));
      if (i == 0) push_ret(1'b0, exp_mem[8'h10], 1'b0);
      step();
    end
    rst = 1'b1;
    #1;
    check_all_zero("mid reset");
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post reset done", 32'(done), 32'd0);
      chk("post reset rd_valid", 32'(rd_valid), 32'd0);
      step();
    end
    v = '{1'b1, 1'b0, 8'h10, 8'd1, 8'h00, 1'b0, 8'h11};
    run_burst(v);
    step(); step();

    chk("p0 returns outstanding", 32'(q0.size()), 32'd0);
    chk("p1 returns outstanding", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
